// File: rtl/gram_result_drain.sv
// rtl/gram_result_drain.sv - Gram PE result drain: beat counter, capture, show-ahead result FIFO.
// Optional drop counter output is enabled by defining GRAM_DRAIN_DROP_CNT_EN.
module gram_result_drain #(
  parameter int WIDTH     = 8,
  parameter int DIMENSION = 4,
  parameter int DEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        in_P,
  input  logic                    in_en,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  input  logic                    clr_ovf
`ifdef GRAM_DRAIN_DROP_CNT_EN
  ,
  output logic [7:0]              drop_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] LAST_BEAT = 5'(DIMENSION - 1);

  logic [4:0]       beat_q, beat_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic capture, empty, full, pop, push, drop;

  assign capture = in_en && (beat_q == LAST_BEAT);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = !empty && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO only drops when nothing leaves.
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  always_comb begin
    beat_d     = 5'd0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (in_en && beat_q != LAST_BEAT) beat_d = beat_q + 5'd1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (drop)         overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q     <= 5'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      beat_q     <= beat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_P;
  end

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign level     = wr_ptr_q - rd_ptr_q;
  assign overflow  = overflow_q;

`ifdef GRAM_DRAIN_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // A clear coinciding with a drop leaves that one drop counted.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr_ovf)                        drop_cnt_d = {7'd0, drop};
    else if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= 8'd0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_gram_result_drain.sv
// tb/tb_gram_result_drain.sv - scoreboard bench for gram_result_drain with random and directed windows.
module tb_gram_result_drain;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int DP = 4;

  logic           clk;
  logic           rst;
  logic [W-1:0]   in_P;
  logic           in_en;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [2:0]     level;
  logic           overflow;
  logic           clr_ovf;
`ifdef GRAM_DRAIN_DROP_CNT_EN
  logic [7:0]     drop_cnt;
`endif

  gram_result_drain #(.WIDTH(W), .DIMENSION(D), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .in_P(in_P), .in_en(in_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .overflow(overflow), .clr_ovf(clr_ovf)
`ifdef GRAM_DRAIN_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a run of consecutive enabled beats completes a dot product every D beats.
  logic [W-1:0] sb[$];
  int           run;
  logic         ovf_m;
  int           dcnt_m;
  logic         cap_m, drp_m;

  always @(posedge clk) begin
    if (!rst) begin
      run   = in_en ? run + 1 : 0;
      cap_m = in_en && (run % D == 0);
      drp_m = 1'b0;
      if (cap_m) begin
        if (sb.size() < DP) sb.push_back(in_P);
        else drp_m = 1'b1;
      end
      if (drp_m) ovf_m = 1'b1;
      else if (clr_ovf) ovf_m = 1'b0;
      if (clr_ovf) dcnt_m = drp_m ? 1 : 0;
      else if (drp_m && dcnt_m < 255) dcnt_m++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", out_valid, sb.size() > 0);
      check("level", level, sb.size());
      check("overflow", overflow, ovf_m);
`ifdef GRAM_DRAIN_DROP_CNT_EN
      check("drop_cnt", drop_cnt, dcnt_m);
`endif
      if (sb.size() == 0) check("out_data_empty", out_data, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("pop_on_empty", out_valid, 0);
        else check("pop_data", out_data, sb.pop_front());
      end
    end
  end

  task automatic step(input logic en, input logic [W-1:0] p, input logic rdy, input logic clr);
    in_en = en; in_P = p; out_ready = rdy; clr_ovf = clr;
    @(posedge clk); #1;
  endtask

  task automatic window(input logic [W-1:0] last, input logic rdy_last);
    for (int i = 0; i < D - 1; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
    step(1'b1, last, rdy_last, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DP + 1; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_en = 1'b0; in_P = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    run = 0; ovf_m = 1'b0; dcnt_m = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", overflow, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Single full window
    step(1'b1, 8'd3, 1'b0, 1'b0);
    step(1'b1, 8'd8, 1'b0, 1'b0);
    step(1'b1, 8'd15, 1'b0, 1'b0);
    check("win1_not_yet", out_valid, 0);
    step(1'b1, 8'd24, 1'b0, 1'b0);
    check("win1_valid", out_valid, 1);
    check("win1_data", out_data, 24);
    check("win1_level", level, 1);
    drain();

    // Partial window then a full one
    step(1'b1, 8'd1, 1'b0, 1'b0);
    step(1'b1, 8'd2, 1'b0, 1'b0);
    step(1'b1, 8'd3, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    check("partial_none", out_valid, 0);
    window(8'd40, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    check("partial_level", level, 1);
    check("partial_data", out_data, 40);
    drain();

    // Back-to-back windows overfill the FIFO
    for (int k = 1; k <= 5; k++) window(W'(k * 10), 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    check("full_level", level, 4);
    check("full_ovf", overflow, 1);
    check("full_head", out_data, 10);
`ifdef GRAM_DRAIN_DROP_CNT_EN
    check("full_dcnt", drop_cnt, 1);
`endif

    // Capture while full with a simultaneous pop
    window(8'd60, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    check("swap_level", level, 4);
    check("swap_ovf", overflow, 1);
    check("swap_head", out_data, 20);
    drain();

    // Clear overflow, then clear coinciding with a drop
    step(1'b0, 8'd0, 1'b0, 1'b1);
    check("clr_ovf", overflow, 0);
    for (int k = 1; k <= 4; k++) window(W'(k), 1'b0);
    for (int i = 0; i < D - 1; i++) step(1'b1, 8'd0, 1'b0, 1'b0);
    step(1'b1, 8'd99, 1'b0, 1'b1);
    check("clr_drop_ovf", overflow, 1);
`ifdef GRAM_DRAIN_DROP_CNT_EN
    check("clr_drop_dcnt", drop_cnt, 1);
`endif
    drain();
    step(1'b0, 8'd0, 1'b0, 1'b1);

    // Async reset mid-window with two results queued
    window(8'd11, 1'b0);
    window(8'd22, 1'b0);
    step(1'b1, 8'd5, 1'b0, 1'b0);
    step(1'b1, 8'd6, 1'b0, 1'b0);
    check("pre_rst_level", level, 2);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_level", level, 0);
    check("arst_data", out_data, 0);
    sb.delete(); run = 0; ovf_m = 1'b0; dcnt_m = 0;
    in_en = 1'b0;
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    window(8'd77, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    check("post_rst_level", level, 1);
    check("post_rst_data", out_data, 77);
    drain();

    // Random traffic
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 99) < 85, W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 99) < 4);
    drain();
    check("final_empty", out_valid, 0);
    check("final_sb", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gram_result_drain.md
Name: gram_result_drain

Overview:
- Collects completed dot products from the P/en_o outputs of one Gram-matrix PE.
- Counts qualified beats of the PE output to find the cycle where P holds a full DIMENSION-term sum.
- Captures that sum into a small show-ahead FIFO and presents it downstream on a valid/ready interface.
- Sits at the output edge of the systolic array, one instance per PE row or column tap.

Parameters:
- WIDTH, 8: data width of P and of the output data.
- DIMENSION, 4: number of products per dot product; must match the PE. Legal range 1..31.
- DEPTH, 4: FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_P  in  WIDTH  P output of the PE.
- in_en  in  1  en_o of the PE; high means in_P is updated this cycle.
- out_data  out  WIDTH  head-of-FIFO result.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts the head this cycle.
- level  out  clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a completed result was dropped.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset (async, rst=1): beat counter=0, FIFO empty, wr/rd pointers=0, out_valid=0, out_data=0, level=0, overflow=0. Takes effect immediately, including mid-window and mid-transfer; a partial sum in progress is discarded.
- Beat counter (0..DIMENSION-1):
  - in_en=1: counter increments; at DIMENSION-1 it wraps to 0.
  - in_en=0: counter clears to 0, mirroring the PE clearing P when en drops.
- Capture event: in_en=1 and counter==DIMENSION-1. in_P in that cycle is the complete sum. Push it, truncated to WIDTH bits exactly as the PE produces it (no widening, no saturation).
- Partial windows: windows shorter than DIMENSION beats (in_en falls early) produce no result.
- FIFO: show-ahead. out_data = entry at the read pointer when out_valid=1, and 0 when empty.
- Pop: out_valid && out_ready at a rising edge.
- Pointers wrap modulo DEPTH using an extra MSB for full/empty discrimination.
- level: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Full + capture + pop in the same cycle: both happen, no drop, level unchanged.
- Full + capture, no pop: the new result is dropped, FIFO contents untouched, overflow<=1.
- Empty + capture: the entry becomes visible (out_valid=1) the cycle after the capture edge. Capture-to-out_valid latency is 1 clock.
- Empty: out_ready is ignored; no pointer movement.
- overflow: sticky until clr_ovf=1 is seen at a rising edge. If clr_ovf and a new drop occur in the same cycle, overflow stays 1 (set wins).
- Back-to-back windows (in_en held high continuously) produce one capture every DIMENSION cycles.
- in_P is never registered except at capture; no combinational path from in_P/in_en to outputs.

Optional Feature:
- Macro GRAM_DRAIN_DROP_CNT_EN.
- Defined: adds output drop_cnt [7:0]. It counts dropped results, saturates at 255, resets to 0 on rst, and clears to 0 on clr_ovf. If a clear and a drop coincide, the result is 1.
- Undefined: drop_cnt port and its logic are absent; overflow alone reports drops.

Test Plan:
- WIDTH=8, DIMENSION=4, DEPTH=4. in_en high 4 cycles, in_P=3,8,15,24 -> one push of 24; out_valid rises the next cycle; out_data=24; level=1.
- in_en high 3 cycles (P=1,2,3), low 1 cycle, then high 4 cycles with final P=40 -> only 40 captured; the partial window yields nothing.
- in_en high 20 continuous cycles with out_ready=0, final P of each window 10,20,30,40,50 -> FIFO holds 10,20,30,40; 50 dropped; overflow=1; drop_cnt=1 when enabled; level=4.
- FIFO full, out_ready=1 on the cycle of a capture of 60 -> pop 10 and push 60; level stays 4; overflow unchanged. Subsequent drain order is 20,30,40,60.
- rst asserted asynchronously mid-window with level=2 -> outputs clear immediately, no clock required. After release, the next full 4-beat window yields exactly one result.
- overflow=1, pulse clr_ovf with no drop -> overflow=0 next edge. Repeat with a simultaneous drop -> overflow stays 1.
